// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU controls and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // 11 means the ALU is idle; alucontrol then reads as 000.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps (aluop, funct) to alucontrol; funct_valid flags a supported
// R-type funct regardless of aluop. Purely combinational.
module mc_aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] rtype_ctl;

  always_comb begin
    funct_valid = 1'b1;
    rtype_ctl   = ALU_AND;
    case (funct)
      FN_ADD:  rtype_ctl = ALU_ADD;
      FN_SUB:  rtype_ctl = ALU_SUB;
      FN_AND:  rtype_ctl = ALU_AND;
      FN_OR:   rtype_ctl = ALU_OR;
      FN_SLT:  rtype_ctl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = rtype_ctl;
      default:     alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with Moore outputs; lw 5, sw/R/addi 4, beq/j 3 cycles.
// FETCH, MEMRD and MEMWR stall one cycle per cycle of mem_ready=0.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, next;
  logic       is_store;
  logic       pcwrite, branch;
  logic [1:0] aluop;
  logic       funct_valid;

  mc_aludec u_aludec (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid)
  );

  // lw/sw is latched in DECODE so MEMADR never looks at op again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE) is_store <= (op == OP_SW);
    end
  end

  always_comb begin
    next       = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_NONE;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        aluop   = ALUOP_ADD;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        aluop   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) next = S_EXECUTE;
            else illegal = 1'b1;
          end
          OP_BEQ:  next = S_BRANCH;
          OP_ADDI: next = S_ADDIEXEC;
          OP_J:    next = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
        next    = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        next       = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
        next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: next = S_FETCH;
    endcase

    // Reset shows FETCH selects with every strobe held low.
    if (reset) begin
      next       = S_FETCH;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_FOUR;
      pcsrc      = PC_ALU;
      aluop      = ALUOP_ADD;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Per-cycle vector bench for mc_controller: every row drives inputs for one
// cycle and checks the full control word against hand-written values.
module tb_mc_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BADOP = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, instr_done, illegal;
  outs_t      got;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
    .instr_done(instr_done), .illegal(illegal)
  );

  assign got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, pcen, instr_done, illegal};

  function automatic outs_t o(logic io, logic mw, logic irw, logic rd, logic mtr,
                              logic rw, logic asa, logic [1:0] asb, logic [1:0] pcs,
                              logic [2:0] alu, logic pe, logic dn, logic il);
    return {io, mw, irw, rd, mtr, rw, asa, asb, pcs, alu, pe, dn, il};
  endfunction

  // Expected control words, written out by hand per state.
  outs_t E_RST, E_F1, E_F0, E_DEC, E_DECI, E_MA, E_MR, E_MWB, E_MW0, E_MW1;
  outs_t E_AWB, E_AE, E_AIWB, E_JMP;

  function automatic outs_t e_ex(logic [2:0] alu);
    return o(0,0,0,0,0,0,1,2'b00,2'b00,alu,0,0,0);
  endfunction

  function automatic outs_t e_br(logic z);
    return o(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,z,1,0);
  endfunction

  function automatic void add(string t, logic r, logic [5:0] opc, logic [5:0] fn,
                              logic z, logic rdy, outs_t e);
    vec_t v;
    v.tag = t; v.rst = r; v.op = opc; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic step(input string t, input logic r, input logic [5:0] opc,
                      input logic [5:0] fn, input logic z, input logic rdy,
                      input outs_t e);
    @(negedge clk);
    reset = r; op = opc; funct = fn; zero = z; mem_ready = rdy;
    #1;
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", t, got, e);
    end
  endtask

  initial begin
    E_RST  = o(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    E_F1   = o(0,0,1,0,0,0,0,2'b01,2'b00,3'b010,1,0,0);
    E_F0   = o(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
    E_DEC  = o(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,0);
    E_DECI = o(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,1);
    E_MA   = o(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    E_MR   = o(1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    E_MWB  = o(0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,1,0);
    E_MW0  = o(1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0);
    E_MW1  = o(1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,1,0);
    E_AWB  = o(0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,1,0);
    E_AE   = o(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
    E_AIWB = o(0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,1,0);
    E_JMP  = o(0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,1,0);

    // tag, reset, op, funct, zero, mem_ready, expected
    add("rst0",    1, RT, 6'd0, 0, 1, E_RST);
    add("rst1",    1, RT, 6'd0, 1, 0, E_RST);
    add("lw_f",    0, LW, 6'd0, 0, 1, E_F1);
    add("lw_d",    0, LW, 6'd0, 0, 1, E_DEC);
    add("lw_ma",   0, SW, 6'd0, 0, 1, E_MA);   // op change after DECODE ignored
    add("lw_mr",   0, SW, 6'd0, 0, 1, E_MR);
    add("lw_wb",   0, SW, 6'd0, 0, 1, E_MWB);
    add("sw_f0",   0, SW, 6'd0, 0, 0, E_F0);
    add("sw_f1",   0, SW, 6'd0, 0, 1, E_F1);
    add("sw_d",    0, SW, 6'd0, 0, 1, E_DEC);
    add("sw_ma",   0, SW, 6'd0, 0, 1, E_MA);
    add("sw_w0",   0, SW, 6'd0, 0, 0, E_MW0);
    add("sw_w1",   0, LW, 6'd0, 1, 0, E_MW0);
    add("sw_w2",   0, SW, 6'd0, 0, 0, E_MW0);
    add("sw_w3",   0, SW, 6'd0, 0, 1, E_MW1);
    add("slt_f",   0, RT, 6'b101010, 1, 1, E_F1);
    add("slt_d",   0, RT, 6'b101010, 1, 1, E_DEC);
    add("slt_ex",  0, RT, 6'b101010, 1, 1, e_ex(3'b111));
    add("slt_wb",  0, RT, 6'b100010, 1, 1, E_AWB);
    add("sub_f",   0, RT, 6'b100010, 0, 1, E_F1);
    add("sub_d",   0, RT, 6'b100010, 0, 1, E_DEC);
    add("sub_ex",  0, RT, 6'b100010, 0, 1, e_ex(3'b110));
    add("sub_wb",  0, RT, 6'b100010, 0, 1, E_AWB);
    add("and_f",   0, RT, 6'b100100, 0, 1, E_F1);
    add("and_d",   0, RT, 6'b100100, 0, 1, E_DEC);
    add("and_ex",  0, RT, 6'b100100, 0, 1, e_ex(3'b000));
    add("and_wb",  0, RT, 6'b100100, 0, 1, E_AWB);
    add("or_f",    0, RT, 6'b100101, 0, 1, E_F1);
    add("or_d",    0, RT, 6'b100101, 0, 1, E_DEC);
    add("or_ex",   0, RT, 6'b100101, 0, 1, e_ex(3'b001));
    add("or_wb",   0, RT, 6'b100101, 0, 1, E_AWB);
    add("add_f",   0, RT, 6'b100000, 0, 1, E_F1);
    add("add_d",   0, RT, 6'b100000, 0, 1, E_DEC);
    add("add_ex",  0, RT, 6'b100000, 0, 1, e_ex(3'b010));
    add("add_wb",  0, RT, 6'b100000, 0, 1, E_AWB);
    add("beq1_f",  0, BEQ, 6'd0, 1, 1, E_F1);
    add("beq1_d",  0, BEQ, 6'd0, 1, 1, E_DEC);
    add("beq1_br", 0, BEQ, 6'd0, 1, 1, e_br(1'b1));
    add("beq0_f",  0, BEQ, 6'd0, 0, 1, E_F1);
    add("beq0_d",  0, BEQ, 6'd0, 1, 1, E_DEC);
    add("beq0_br", 0, BEQ, 6'd0, 0, 1, e_br(1'b0));
    add("addi_f",  0, ADDI, 6'd0, 0, 1, E_F1);
    add("addi_d",  0, ADDI, 6'd0, 0, 1, E_DEC);
    add("addi_ex", 0, ADDI, 6'd0, 0, 1, E_AE);
    add("addi_wb", 0, ADDI, 6'd0, 0, 1, E_AIWB);
    add("j_f",     0, JMP, 6'd0, 0, 1, E_F1);
    add("j_d",     0, JMP, 6'd0, 0, 1, E_DEC);
    add("j_jmp",   0, JMP, 6'd0, 0, 1, E_JMP);
    add("ilop_f",  0, BADOP, 6'd0, 0, 1, E_F1);
    add("ilop_d",  0, BADOP, 6'd0, 0, 1, E_DECI);
    add("ilfn_f",  0, RT, 6'd0, 0, 1, E_F1);
    add("ilfn_d",  0, RT, 6'd0, 0, 1, E_DECI);
    add("ilfn_nf", 0, RT, 6'd0, 0, 1, E_F1);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].tag, tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy, tbl[i].exp);

    // Reset while stalled in MEMRD: strobes low, restart at FETCH.
    step("mr_d",     0, LW, 6'd0, 0, 1, E_DEC);
    step("mr_ma",    0, LW, 6'd0, 0, 1, E_MA);
    step("mr_wait0", 0, LW, 6'd0, 0, 0, E_MR);
    step("mr_wait1", 0, LW, 6'd0, 0, 0, E_MR);
    step("mr_rst0",  1, LW, 6'd0, 0, 0, E_RST);
    step("mr_rst1",  1, LW, 6'd0, 1, 1, E_RST);
    step("mr_post0", 0, SW, 6'd0, 0, 0, E_F0);

    // Reset while MEMWR is waiting: memwrite must drop immediately.
    step("mw_f",     0, SW, 6'd0, 0, 1, E_F1);
    step("mw_d",     0, SW, 6'd0, 0, 1, E_DEC);
    step("mw_ma",    0, SW, 6'd0, 0, 1, E_MA);
    step("mw_wait",  0, SW, 6'd0, 0, 0, E_MW0);
    step("mw_rst",   1, SW, 6'd0, 0, 1, E_RST);
    step("mw_post",  0, SW, 6'd0, 0, 1, E_F1);
    step("mw_post_d",0, SW, 6'd0, 0, 1, E_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
